// File: rtl/instr_encoder_pkg.sv
// Shared types and RV64 encoding constants for the instruction encoder slice.
package instr_encoder_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef enum logic [3:0] {
        OP_ADDI  = 4'd0,
        OP_XORI  = 4'd1,
        OP_ORI   = 4'd2,
        OP_ANDI  = 4'd3,
        OP_LD    = 4'd4,
        OP_JALR  = 4'd5,
        OP_SD    = 4'd6,
        OP_LUI   = 4'd7,
        OP_AUIPC = 4'd8,
        OP_JAL   = 4'd9
    } op_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_XORI = 3'b100;
    localparam logic [2:0] F3_ORI  = 3'b110;
    localparam logic [2:0] F3_ANDI = 3'b111;
    localparam logic [2:0] F3_LD   = 3'b011;
    localparam logic [2:0] F3_SD   = 3'b011;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam u32 INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        u32   instr;
        u64   addr;
        logic err;
    } entry_t;

    // True when v is a sign extension of its low (msb+1) bits.
    function automatic logic sext_fits(input u64 v, input int unsigned msb);
        u64 s;
        s = u64'($signed(v) >>> msb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_fmt_enc.sv
// Combinational RV64 format encoder: selects I/S/U/J layout and flags out-of-range immediates.
module instr_fmt_enc
    import instr_encoder_pkg::*;
(
    input  op_t        op,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  u64         imm,
    output u32         instr,
    output logic       err
);

    logic i_ok;
    logic u_ok;
    logic j_ok;

    assign i_ok = sext_fits(imm, 11);
    assign u_ok = (imm[11:0] == 12'd0) && sext_fits(imm, 31);
    assign j_ok = !imm[0] && sext_fits(imm, 20);

    // Out-of-range immediates still produce the truncated encoding; only err reports it.
    always_comb begin
        instr = INSTR_NOP;
        err   = 1'b1;
        case (op)
            OP_ADDI:  begin instr = {imm[11:0], rs1, F3_ADDI, rd, OPC_OP_IMM}; err = !i_ok; end
            OP_XORI:  begin instr = {imm[11:0], rs1, F3_XORI, rd, OPC_OP_IMM}; err = !i_ok; end
            OP_ORI:   begin instr = {imm[11:0], rs1, F3_ORI,  rd, OPC_OP_IMM}; err = !i_ok; end
            OP_ANDI:  begin instr = {imm[11:0], rs1, F3_ANDI, rd, OPC_OP_IMM}; err = !i_ok; end
            OP_LD:    begin instr = {imm[11:0], rs1, F3_LD,   rd, OPC_LOAD};   err = !i_ok; end
            OP_JALR:  begin instr = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};   err = !i_ok; end
            OP_SD:    begin
                instr = {imm[11:5], rs2, rs1, F3_SD, imm[4:0], OPC_STORE};
                err   = !i_ok;
            end
            OP_LUI:   begin instr = {imm[31:12], rd, OPC_LUI};   err = !u_ok; end
            OP_AUIPC: begin instr = {imm[31:12], rd, OPC_AUIPC}; err = !u_ok; end
            OP_JAL:   begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                err   = !j_ok;
            end
            default:  begin instr = INSTR_NOP; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: format encoder, address counter and 2-entry in-order output buffer.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter u64 PC_BASE = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  op_t        op,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  u64         imm,
    input  logic       set_pc,
    input  u64         set_pc_addr,
    output logic       out_valid,
    input  logic       out_ready,
    output u32         out_instr,
    output u64         out_addr,
    output logic       out_err
);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_t;

    occ_t   occ, occ_nxt;
    entry_t main_q, skid_q, new_e;
    u64     pc_q, pc_nxt;
    u32     enc_instr;
    logic   enc_err;
    logic   push, pop;
    logic   load_main, load_skid, shift_skid;

    instr_fmt_enc u_fmt (
        .op    (op),
        .rd    (rd),
        .rs1   (rs1),
        .rs2   (rs2),
        .imm   (imm),
        .instr (enc_instr),
        .err   (enc_err)
    );

    assign in_ready  = (occ != OCC_FULL);
    assign out_valid = (occ != OCC_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        new_e       = '0;
        new_e.instr = enc_instr;
        new_e.err   = enc_err;
        new_e.addr  = set_pc ? set_pc_addr : pc_q;
    end

    always_comb begin
        pc_nxt = pc_q;
        if (push)
            pc_nxt = new_e.addr + 64'd4;
        else if (set_pc)
            pc_nxt = set_pc_addr;
    end

    // main_q always holds the oldest entry; skid_q only fills while main_q is stalled.
    always_comb begin
        occ_nxt    = occ;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        case (occ)
            OCC_EMPTY: begin
                if (push) begin
                    load_main = 1'b1;
                    occ_nxt   = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    load_main = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    occ_nxt   = OCC_FULL;
                end else if (pop) begin
                    occ_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    shift_skid = 1'b1;
                    occ_nxt    = OCC_ONE;
                end
            end
            default: occ_nxt = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ    <= OCC_EMPTY;
            main_q <= '0;
            skid_q <= '0;
            pc_q   <= PC_BASE;
        end else begin
            occ  <= occ_nxt;
            pc_q <= pc_nxt;
            if (load_main)
                main_q <= new_e;
            else if (shift_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= new_e;
        end
    end

    assign out_instr = main_q.instr;
    assign out_addr  = main_q.addr;
    assign out_err   = main_q.err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, corner sequences, random traffic vs reference model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam u64 PC_BASE = 64'h8000_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    op_t        op;
    logic [4:0] rd, rs1, rs2;
    u64         imm;
    logic       set_pc;
    u64         set_pc_addr;
    logic       out_valid;
    logic       out_ready;
    u32         out_instr;
    u64         out_addr;
    logic       out_err;

    instr_encoder #(.PC_BASE(PC_BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .set_pc      (set_pc),
        .set_pc_addr (set_pc_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_t        op;
        logic [4:0] rd, rs1, rs2;
        u64         imm;
    } req_t;

    typedef struct {
        u32   instr;
        u64   addr;
        logic err;
    } exp_t;

    typedef struct {
        logic rst;
        req_t r;
        u32   instr;
        logic err;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    u64   m_pc;
    vec_t tab[15];

    function automatic void check(input string name, input logic ok, input string got, input string want);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, got, want);
        end
    endfunction

    // Reference encoder built from numeric range rules and field layouts.
    function automatic void ref_enc(input req_t r, output u32 ins, output logic er);
        longint s;
        s = $signed(r.imm);
        ins = 32'h0000_0013;
        er  = 1'b1;
        case (r.op)
            OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_LD, OP_JALR, OP_SD: begin
                er = (s < -2048) || (s > 2047);
                case (r.op)
                    OP_ADDI: ins = {r.imm[11:0], r.rs1, 3'b000, r.rd, 7'b0010011};
                    OP_XORI: ins = {r.imm[11:0], r.rs1, 3'b100, r.rd, 7'b0010011};
                    OP_ORI:  ins = {r.imm[11:0], r.rs1, 3'b110, r.rd, 7'b0010011};
                    OP_ANDI: ins = {r.imm[11:0], r.rs1, 3'b111, r.rd, 7'b0010011};
                    OP_LD:   ins = {r.imm[11:0], r.rs1, 3'b011, r.rd, 7'b0000011};
                    OP_JALR: ins = {r.imm[11:0], r.rs1, 3'b000, r.rd, 7'b1100111};
                    default: ins = {r.imm[11:5], r.rs2, r.rs1, 3'b011, r.imm[4:0], 7'b0100011};
                endcase
            end
            OP_LUI, OP_AUIPC: begin
                er  = (r.imm[11:0] != 12'd0) || (s != longint'($signed(r.imm[31:0])));
                ins = {r.imm[31:12], r.rd, (r.op == OP_LUI) ? 7'b0110111 : 7'b0010111};
            end
            OP_JAL: begin
                er  = r.imm[0] || (s < -1048576) || (s > 1048574);
                ins = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, 7'b1101111};
            end
            default: begin
                ins = 32'h0000_0013;
                er  = 1'b1;
            end
        endcase
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.op  = op_t'(4'($urandom_range(0, 11)));
        r.rd  = 5'($urandom);
        r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom);
        case ($urandom_range(0, 3))
            0: r.imm = u64'(longint'($urandom_range(0, 6000)) - 3000);
            1: r.imm = u64'(longint'($signed($urandom & 32'hFFFF_F000)));
            2: r.imm = u64'(longint'($urandom_range(0, 4200000)) - 2100000);
            default: r.imm = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    function automatic req_t mk(input op_t o, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input u64 im);
        req_t r;
        r.op = o; r.rd = d; r.rs1 = s1; r.rs2 = s2; r.imm = im;
        return r;
    endfunction

    // Called at a falling edge; the inputs set here are sampled at the next rising edge.
    task automatic step(input logic iv, input req_t r, input logic ordy, input logic sp,
                        input u64 spa, input logic use_tab, input u32 t_instr,
                        input logic t_err, output logic acc);
        int   size0;
        exp_t e;
        size0 = sb.size();
        check("out_valid", out_valid === (size0 != 0), $sformatf("%b", out_valid),
              $sformatf("%b", size0 != 0));
        check("in_ready", in_ready === (size0 < 2), $sformatf("%b", in_ready),
              $sformatf("%b", size0 < 2));
        if (size0 != 0) begin
            e = sb[0];
            check("out_entry",
                  (out_instr === e.instr) && (out_addr === e.addr) && (out_err === e.err),
                  $sformatf("%h@%h err=%b", out_instr, out_addr, out_err),
                  $sformatf("%h@%h err=%b", e.instr, e.addr, e.err));
            if (ordy)
                void'(sb.pop_front());
        end
        acc         = iv && (size0 < 2);
        in_valid    = iv;
        op          = r.op;
        rd          = r.rd;
        rs1         = r.rs1;
        rs2         = r.rs2;
        imm         = r.imm;
        out_ready   = ordy;
        set_pc      = sp;
        set_pc_addr = spa;
        if (acc) begin
            e.addr = sp ? spa : m_pc;
            m_pc   = e.addr + 64'd4;
            if (use_tab) begin
                e.instr = t_instr;
                e.err   = t_err;
            end else begin
                ref_enc(r, e.instr, e.err);
            end
            sb.push_back(e);
        end else if (sp) begin
            m_pc = spa;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, mk(OP_ADDI, 0, 0, 0, 0), ordy, 1'b0, '0, 1'b0, '0, 1'b0, acc);
    endtask

    task automatic do_reset(input logic iv);
        reset     = 1'b1;
        in_valid  = iv;
        op        = OP_ADDI;
        imm       = 64'd1;
        out_ready = 1'b0;
        set_pc    = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        m_pc = PC_BASE;
        check("rst_out_valid", out_valid === 1'b0, $sformatf("%b", out_valid), "0");
        check("rst_out_fields", (out_instr === '0) && (out_addr === '0) && (out_err === 1'b0),
              $sformatf("%h@%h err=%b", out_instr, out_addr, out_err), "0@0 err=0");
        check("rst_in_ready", in_ready === 1'b1, $sformatf("%b", in_ready), "1");
    endtask

    function automatic void set_vec(input int i, input logic rs, input req_t r,
                                    input u32 ins, input logic er);
        tab[i].rst = rs; tab[i].r = r; tab[i].instr = ins; tab[i].err = er;
    endfunction

    initial begin
        logic acc;
        req_t rq[3];
        int   k;

        set_vec(0,  1, mk(OP_ADDI, 1, 0, 0, 64'd5),                   32'h0050_0093, 0);
        set_vec(1,  1, mk(OP_LUI, 5, 0, 0, 64'h1234_5000),            32'h1234_52B7, 0);
        set_vec(2,  0, mk(OP_SD, 31, 3, 2, 64'hFFFF_FFFF_FFFF_FFF8),  32'hFE21_BC23, 0);
        set_vec(3,  0, mk(OP_JAL, 1, 0, 0, 64'd8),                    32'h0080_00EF, 0);
        set_vec(4,  0, mk(OP_ADDI, 1, 0, 0, 64'd2048),                32'h8000_0093, 1);
        set_vec(5,  0, mk(OP_JAL, 1, 0, 0, 64'd3),                    32'h0020_00EF, 1);
        set_vec(6,  0, mk(op_t'(4'd12), 1, 2, 3, 64'd0),              32'h0000_0013, 1);
        set_vec(7,  0, mk(OP_ADDI, 1, 0, 0, 64'hFFFF_FFFF_FFFF_F800), 32'h8000_0093, 0);
        set_vec(8,  0, mk(OP_ADDI, 1, 0, 0, 64'd2047),                32'h7FF0_0093, 0);
        set_vec(9,  0, mk(OP_JAL, 1, 0, 0, 64'h000F_FFFE),            32'h7FFF_F0EF, 0);
        set_vec(10, 0, mk(OP_JAL, 1, 0, 0, 64'h0010_0000),            32'h8000_00EF, 1);
        set_vec(11, 0, mk(OP_LUI, 5, 0, 0, 64'h1234_5001),            32'h1234_52B7, 1);
        set_vec(12, 0, mk(OP_ADDI, 1, 0, 0, 64'hFFFF_FFFF_FFFF_F7FF), 32'h7FF0_0093, 1);
        set_vec(13, 0, mk(OP_AUIPC, 5, 0, 0, 64'hFFFF_FFFF_8000_0000), 32'h8000_0297, 0);
        set_vec(14, 0, mk(OP_AUIPC, 5, 0, 0, 64'h0000_0000_8000_0000), 32'h8000_0297, 1);

        reset = 1'b1; in_valid = 1'b0; op = OP_ADDI; rd = '0; rs1 = '0; rs2 = '0;
        imm = '0; set_pc = 1'b0; set_pc_addr = '0; out_ready = 1'b0;
        m_pc = PC_BASE;
        repeat (2) @(negedge clk);

        // Directed vectors, one request at a time with the sink always ready.
        for (int i = 0; i < 15; i++) begin
            if (tab[i].rst)
                do_reset(1'b0);
            step(1'b1, tab[i].r, 1'b1, 1'b0, '0, 1'b1, tab[i].instr, tab[i].err, acc);
        end
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: sink stalled 4 cycles while 3 requests are offered.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) rq[i] = rand_req();
        k = 0;
        for (int c = 0; c < 4; c++) begin
            step(k < 3, rq[k < 3 ? k : 2], 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, acc);
            if (acc) k++;
        end
        check("stall_accepts", k == 2, $sformatf("%0d", k), "2");
        for (int c = 0; c < 10 && k < 3; c++) begin
            step(1'b1, rq[k], 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, acc);
            if (acc) k++;
        end
        check("stall_release", k == 3, $sformatf("%0d", k), "3");
        repeat (3) idle(1'b1);

        // set_pc together with an accept, then 64-bit wrap of the counter.
        do_reset(1'b0);
        step(1'b1, rand_req(), 1'b1, 1'b1, 64'h1000, 1'b0, '0, 1'b0, acc);
        step(1'b1, rand_req(), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, acc);
        step(1'b0, rand_req(), 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, '0, 1'b0, acc);
        step(1'b1, rand_req(), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, acc);
        step(1'b1, rand_req(), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, acc);
        repeat (2) idle(1'b1);

        // Reset with two entries buffered and a request offered in the same cycle.
        do_reset(1'b0);
        step(1'b1, rand_req(), 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, acc);
        step(1'b1, rand_req(), 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, acc);
        check("pre_reset_full", in_ready === 1'b0, $sformatf("%b", in_ready), "0");
        do_reset(1'b1);
        step(1'b1, rand_req(), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, acc);
        repeat (2) idle(1'b1);

        // Random traffic with random back-pressure and occasional set_pc.
        do_reset(1'b0);
        for (int c = 0; c < 500; c++) begin
            step(1'($urandom_range(0, 1)), rand_req(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, {$urandom, $urandom}, 1'b0, '0, 1'b0, acc);
        end
        for (int c = 0; c < 10 && sb.size() != 0; c++)
            idle(1'b1);
        check("drain", sb.size() == 0, $sformatf("%0d left", sb.size()), "0 left");
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
